// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR word generator: maximal-length tap
// masks per width, the default seed and parameter legality checks.
package lfsr_pkg;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

    // Tap masks use the same convention as the generator: bit i set means state[i] feeds the XOR.
    localparam logic [31:0] TAPS_W4  = 32'h0000_000C;
    localparam logic [31:0] TAPS_W5  = 32'h0000_0014;
    localparam logic [31:0] TAPS_W6  = 32'h0000_0030;
    localparam logic [31:0] TAPS_W7  = 32'h0000_0060;
    localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_W9  = 32'h0000_0110;
    localparam logic [31:0] TAPS_W10 = 32'h0000_0240;
    localparam logic [31:0] TAPS_W11 = 32'h0000_0500;
    localparam logic [31:0] TAPS_W12 = 32'h0000_0829;
    localparam logic [31:0] TAPS_W13 = 32'h0000_100D;
    localparam logic [31:0] TAPS_W14 = 32'h0000_2015;
    localparam logic [31:0] TAPS_W15 = 32'h0000_6000;
    localparam logic [31:0] TAPS_W16 = 32'h0000_D008;
    localparam logic [31:0] TAPS_W17 = 32'h0001_2000;
    localparam logic [31:0] TAPS_W18 = 32'h0002_0400;
    localparam logic [31:0] TAPS_W19 = 32'h0004_0023;
    localparam logic [31:0] TAPS_W20 = 32'h0009_0000;
    localparam logic [31:0] TAPS_W21 = 32'h0014_0000;
    localparam logic [31:0] TAPS_W22 = 32'h0030_0000;
    localparam logic [31:0] TAPS_W23 = 32'h0042_0000;
    localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_W25 = 32'h0120_0000;
    localparam logic [31:0] TAPS_W26 = 32'h0200_0023;
    localparam logic [31:0] TAPS_W27 = 32'h0400_0013;
    localparam logic [31:0] TAPS_W28 = 32'h0900_0000;
    localparam logic [31:0] TAPS_W29 = 32'h1400_0000;
    localparam logic [31:0] TAPS_W30 = 32'h2000_0029;
    localparam logic [31:0] TAPS_W31 = 32'h4800_0000;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    function automatic logic [31:0] max_taps(input int width);
        case (width)
            4:  return TAPS_W4;
            5:  return TAPS_W5;
            6:  return TAPS_W6;
            7:  return TAPS_W7;
            8:  return TAPS_W8;
            9:  return TAPS_W9;
            10: return TAPS_W10;
            11: return TAPS_W11;
            12: return TAPS_W12;
            13: return TAPS_W13;
            14: return TAPS_W14;
            15: return TAPS_W15;
            16: return TAPS_W16;
            17: return TAPS_W17;
            18: return TAPS_W18;
            19: return TAPS_W19;
            20: return TAPS_W20;
            21: return TAPS_W21;
            22: return TAPS_W22;
            23: return TAPS_W23;
            24: return TAPS_W24;
            25: return TAPS_W25;
            26: return TAPS_W26;
            27: return TAPS_W27;
            28: return TAPS_W28;
            29: return TAPS_W29;
            30: return TAPS_W30;
            31: return TAPS_W31;
            32: return TAPS_W32;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= 4) && (width <= 32);
    endfunction

    function automatic bit steps_ok(input int width, input int steps);
        return (steps >= 1) && (steps <= width);
    endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational word advance: STEPS chained single steps of the Fibonacci
// LFSR, shifting left with the tap parity entering bit 0.
module lfsr_advance #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(32'h0000_D008),
    parameter int              STEPS = 1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] stage [0:STEPS];

    assign stage[0] = cur;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        assign stage[k+1] = {stage[k][WIDTH-2:0], ^(stage[k] & TAPS)};
    end

    assign nxt = stage[STEPS];

endmodule

// File: rtl/lfsr_prng.sv
// Pseudo-random word generator: LFSR state, reseed handling, period detection
// and a registered valid/ready output stage.
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             seed_err,
    output logic             wrap
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("lfsr_prng: WIDTH must be in 4..32");
    end
    if (!steps_ok(WIDTH, STEPS)) begin : g_bad_steps
        $error("lfsr_prng: STEPS must be in 1..WIDTH");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_prng: SEED must be non-zero");
    end
    if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_taps
        $error("lfsr_prng: TAPS must include bit WIDTH-1");
    end

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] origin;
    logic [WIDTH-1:0] advanced;
    logic             fire;
    logic             gen;

    lfsr_advance #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .STEPS (STEPS)
    ) u_advance (
        .cur (state),
        .nxt (advanced)
    );

    // Handshake: a word transfers on any edge where out_valid && out_ready.
    // Once out_valid is high, out_data is frozen and out_valid stays high until
    // that transfer or a load; en only gates production of new words.
    assign fire = out_valid & out_ready;
    assign gen  = en & (~out_valid | fire);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= SEED;
            origin    <= SEED;
            out_data  <= '0;
            out_valid <= 1'b0;
            seed_err  <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            seed_err <= 1'b0;
            wrap     <= 1'b0;
            if (load) begin
                // Zero would lock the LFSR, so it is replaced and flagged.
                if (seed_in == '0) begin
                    state    <= SEED;
                    origin   <= SEED;
                    seed_err <= 1'b1;
                end else begin
                    state  <= seed_in;
                    origin <= seed_in;
                end
                out_valid <= 1'b0;
            end else if (gen) begin
                state     <= advanced;
                out_data  <= advanced;
                out_valid <= 1'b1;
                wrap      <= (advanced == origin);
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: table of per-cycle vectors plus hand-written
// sequences for reset abort, full period and the STEPS=16 relation.
module tb_lfsr_prng;

    logic        clk;
    logic        resetn;
    logic        en;
    logic        load;
    logic [15:0] seed_in;
    logic        out_ready;

    logic        out_valid,   out_valid16;
    logic [15:0] out_data,    out_data16;
    logic        seed_err,    seed_err16;
    logic        wrap,        wrap16;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];

    lfsr_prng u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .load      (load),
        .seed_in   (seed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .seed_err  (seed_err),
        .wrap      (wrap)
    );

    lfsr_prng #(.STEPS(16)) u_dut16 (
        .clk       (clk),
        .resetn    (resetn),
        .en        (en),
        .load      (load),
        .seed_in   (seed_in),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .out_data  (out_data16),
        .seed_err  (seed_err16),
        .wrap      (wrap16)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        resetn    = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        seed_in   = 16'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Driver
    task automatic drive(input logic e, input logic r, input logic l, input logic [15:0] s);
        en        = e;
        out_ready = r;
        load      = l;
        seed_in   = s;
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference single step for the default taps
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hD008)};
    endfunction

    typedef struct {
        logic        en;
        logic        rdy;
        logic        ld;
        logic [15:0] seed;
        logic        ev;
        logic [15:0] ed;
        logic        es;
        logic        ew;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic e, input logic r, input logic l, input logic [15:0] s,
                       input logic ev, input logic [15:0] ed, input logic es, input logic ew);
        vec_t v;
        v.en = e; v.rdy = r; v.ld = l; v.seed = s;
        v.ev = ev; v.ed = ed; v.es = es; v.ew = ew;
        vecs.push_back(v);
    endtask

    initial begin
        logic [15:0] model, model16, w;
        int mism, mism16, zeros, early, bubbles;
        logic last_wrap;
        logic [15:0] last_data;

        // Stimulus table: inputs for the next edge, outputs expected after it
        add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h0002, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h0004, 0, 0);
        for (int i = 0; i < 10; i++)
            add(logic'(i % 2), 0, 0, 16'h0000, 1, 16'h0004, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h0008, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h0011, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h0022, 0, 0);
        add(0, 1, 0, 16'h0000, 0, 16'h0022, 0, 0);
        add(0, 1, 0, 16'h0000, 0, 16'h0022, 0, 0);
        add(0, 1, 1, 16'h0000, 0, 16'h0022, 1, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h0002, 0, 0);
        add(1, 1, 1, 16'h8000, 0, 16'h0002, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h0001, 0, 0);
        add(1, 0, 1, 16'h1234, 0, 16'h0001, 0, 0);
        add(1, 0, 0, 16'h0000, 1, 16'h2469, 0, 0);
        add(1, 0, 0, 16'h0000, 1, 16'h2469, 0, 0);
        add(1, 1, 0, 16'h0000, 1, 16'h48D3, 0, 0);

        do_reset();
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset out_data", 32'(out_data), 32'h0);
        check("reset seed_err", 32'(seed_err), 32'h0);
        check("reset wrap", 32'(wrap), 32'h0);
        check("reset out_valid16", 32'(out_valid16), 32'h0);
        check("reset seed_err16", 32'(seed_err16), 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].ld, vecs[i].seed);
            step_clk();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].ed));
            check($sformatf("vec%0d seed_err", i), 32'(seed_err), 32'(vecs[i].es));
            check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].ew));
        end

        // Reset pulsed inside a cycle aborts the pending word
        drive(1, 1, 0, 16'h0000);
        step_clk();
        #2;
        resetn = 1'b0;
        #1;
        check("midreset out_valid", 32'(out_valid), 32'h0);
        check("midreset out_data", 32'(out_data), 32'h0);
        check("midreset out_valid16", 32'(out_valid16), 32'h0);
        #1;
        resetn = 1'b1;
        step_clk();
        check("restart word1 valid", 32'(out_valid), 32'h1);
        check("restart word1 data", 32'(out_data), 32'h0002);
        step_clk();
        check("restart word2 data", 32'(out_data), 32'h0004);

        // Full period from reset, with the STEPS=16 instance checked alongside
        do_reset();
        drive(1, 1, 0, 16'h0000);
        model = 16'h0001;
        model16 = 16'h0001;
        mism = 0; mism16 = 0; zeros = 0; early = 0; bubbles = 0;
        last_wrap = 1'b0;
        last_data = 16'h0;
        for (int k = 1; k <= 65535; k++) begin
            step_clk();
            model = ref_step(model);
            exp_q.push_back(model);
            w = exp_q.pop_front();
            if (out_data !== w) begin
                if (mism < 4) $display("FAIL period word %0d: got 0x%0h, expected 0x%0h", k, out_data, w);
                mism++;
            end
            if (out_valid !== 1'b1) bubbles++;
            if (out_data == 16'h0) zeros++;
            if (wrap && k < 65535) early++;
            if (k == 65535) begin
                last_wrap = wrap;
                last_data = out_data;
            end
            if (k <= 8) begin
                for (int j = 0; j < 16; j++) model16 = ref_step(model16);
                if (out_data16 !== model16) begin
                    $display("FAIL steps16 word %0d: got 0x%0h, expected 0x%0h", k, out_data16, model16);
                    mism16++;
                end
            end
        end
        check("period word mismatches", 32'(mism), 32'h0);
        check("period bubbles", 32'(bubbles), 32'h0);
        check("period zero words", 32'(zeros), 32'h0);
        check("period early wraps", 32'(early), 32'h0);
        check("period wrap at 65535", 32'(last_wrap), 32'h1);
        check("period data at 65535", 32'(last_data), 32'h0001);
        check("steps16 mismatches", 32'(mism16), 32'h0);
        step_clk();
        check("post-wrap wrap low", 32'(wrap), 32'h0);
        check("post-wrap data", 32'(out_data), 32'h0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised pseudo-random word generator: a Fibonacci LFSR of configurable width, tap mask and seed. It advances a configurable number of steps per delivered word and presents words on a valid/ready stream. It replaces the fixed 16-bit free-running generator used for stimulus and random selection in the processor datapath, adding reset, reseeding, flow control, enable gating and period detection.

## Interface
Parameters:
- WIDTH, 16: LFSR and output width, legal range 4..32.
- TAPS, 16'hD008: feedback tap mask, bit i set means state[i] feeds the XOR. The default is x^16+x^15+x^13+x^4+1, which is maximal-length.
- SEED, 16'h0001: reset state and substitute for a zero load; must be non-zero.
- STEPS, 1: LFSR advances per generated word, legal range 1..WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- resetn, input, 1: asynchronous active-low reset.
- en, input, 1: permits generation of new words.
- load, input, 1: reseed strobe, sampled on clk.
- seed_in, input, WIDTH: seed value captured when load=1.
- out_valid, output, 1: out_data holds an undelivered word.
- out_ready, input, 1: consumer accepts the word.
- out_data, output, WIDTH: generated word, registered.
- seed_err, output, 1: one-cycle pulse when a zero seed was loaded and replaced by SEED.
- wrap, output, 1: one-cycle pulse coincident with the first out_valid cycle of a word whose value equals the current origin seed.

## Operation
- Single step: next = {s[WIDTH-2:0], ^(s & TAPS)}. A word advance applies STEPS single steps combinationally.
- Registers:
  - state: current LFSR value.
  - origin: the most recently applied seed.
  - out_data, out_valid.
  - seed_err, wrap.
- fire = out_valid & out_ready.
- Per-cycle priority:
  1. load=1:
     - state and origin take seed_in; if seed_in==0 they take SEED and seed_err=1.
     - out_valid goes to 0; a pending word is discarded.
     - No word is generated this cycle.
  2. Otherwise, en=1 and (out_valid==0 or fire):
     - state takes the word advance of state; out_data takes the same value; out_valid goes to 1.
     - wrap=1 if that value equals origin.
  3. Otherwise, fire and en=0: out_valid goes to 0 and state holds.
  4. Otherwise, all registers hold.
- Valid/ready rule: once out_valid=1, out_data is stable and out_valid stays high until fire or load. Dropping en never withdraws a pending word.
- state can never reach zero: seeds are non-zero and TAPS must contain bit WIDTH-1. With a maximal TAPS and STEPS=1, wrap recurs every 2^WIDTH-1 delivered words.

## Timing
- Reset values (asynchronous, effective immediately while resetn=0):
  - state = SEED, origin = SEED.
  - out_data = 0, out_valid = 0, seed_err = 0, wrap = 0.
- First word: out_valid rises on the first clk edge after reset release where en=1.
- Latency: one cycle from an en-qualified cycle to the new out_data. A continuous stream with out_ready=1 and en=1 delivers one word per cycle with no bubbles.
- Under back-pressure (out_ready=0), no advance occurs; out_data holds indefinitely.
- load has one cycle of latency. The earliest word after load is generated on the next clk edge with en=1 and equals advance(new seed).
- load together with fire: the word counts as consumed and load takes priority; no new word is produced that cycle.
- seed_err and wrap are high for exactly one clk cycle and return to 0 on the next edge.
- Reset asserted mid-stream aborts the pending word. out_valid drops asynchronously and the sequence restarts from SEED.

## Structure
- Shared package lfsr_pkg holds:
  - constants for maximal tap masks for widths 4..32;
  - the default SEED;
  - width legality checks.
- Sub-module lfsr_advance is a purely combinational STEPS-fold unroll of the single-step function, parametrised by WIDTH, TAPS and STEPS.
- The top level contains the state, origin and output registers and the priority logic. All regs are reset asynchronously on the negedge of resetn.

## Test plan
- Reset, then en=1 and out_ready=1 with defaults:
  - out_data sequence 0x0002, 0x0004, 0x0008, 0x0011, 0x0022, one per cycle;
  - out_valid rises one cycle after en.
- Back-pressure: assert out_ready=0 after word 0x0004. out_data holds 0x0004 with out_valid=1 for 10 cycles; with en toggling in the same window, no change. On release, the next word is 0x0008.
- Full period, defaults, free-running stream: wrap pulses exactly at delivered word 65535, with out_data==0x0001; no zero word ever appears.
- Load handling:
  - load with seed_in=0: seed_err pulses one cycle and the next word is 0x0002.
  - load with seed_in=0x8000: the next word is 0x0001. Feedback here is bit 15 only, which is 1.
  - load asserted during a pending word discards that word.
- STEPS=16 instance versus STEPS=1 instance, same seed: word n of STEPS=16 equals word 16n of STEPS=1, for n=1..8.
- resetn pulsed low mid-stream for a partial cycle: out_valid=0 immediately; after release, the sequence restarts at 0x0002.
